// File: rtl/freq_meter_pkg.sv
// Shared widths, defaults and FSM encoding for the frequency-meter datapath.
package freq_meter_pkg;

  localparam int CNT_W  = 32;
  localparam int PROD_W = 64;
  localparam int unsigned REF_CLK_HZ_DEF = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } calc_state_e;

  // Clamp a wide quotient into the 32-bit result range.
  function automatic logic [CNT_W-1:0] sat_to_cnt(input logic [PROD_W-1:0] v);
    return (|v[PROD_W-1:CNT_W]) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/seq_div_64x32.sv
// Restoring radix-2 divider: 64-bit dividend / 32-bit divisor, one quotient bit per clock.
module seq_div_64x32
  import freq_meter_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [PROD_W-1:0] i_dividend,
  input  logic [CNT_W-1:0]  i_divisor,
  output logic              o_done,
  output logic [PROD_W-1:0] o_quotient
);

  localparam int STEP_W = $clog2(PROD_W);

  logic [CNT_W-1:0]  r_rem;
  logic [PROD_W-1:0] r_quo;
  logic [STEP_W-1:0] r_left;
  logic              r_run;
  logic              r_done;

  logic [CNT_W-1:0]  w_rem_in;
  logic [PROD_W-1:0] w_quo_in;
  logic [CNT_W:0]    w_shift;
  logic              w_fit;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic [PROD_W-1:0] w_quo_nxt;

  // The start cycle already performs the first step, so the last bit lands
  // 64 edges after start and done is visible in the following cycle.
  always_comb begin
    w_rem_in  = i_start ? '0 : r_rem;
    w_quo_in  = i_start ? i_dividend : r_quo;
    w_shift   = {w_rem_in, w_quo_in[PROD_W-1]};
    w_fit     = (w_shift >= {1'b0, i_divisor});
    w_rem_nxt = w_fit ? (w_shift[CNT_W-1:0] - i_divisor) : w_shift[CNT_W-1:0];
    w_quo_nxt = {w_quo_in[PROD_W-2:0], w_fit};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_left <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_left <= STEP_W'(PROD_W - 1);
        r_run  <= 1'b1;
      end else if (r_run) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_left <= r_left - 1'b1;
        if (r_left == STEP_W'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/freq_calc.sv
// Converts buffered gate counts into Hz: freq = sig_cnt * REF_CLK_HZ / ref_cnt,
// with change detection, a one-deep pending slot, saturation and error flags.
module freq_calc
  import freq_meter_pkg::*;
#(
  parameter int unsigned REF_CLK_HZ = REF_CLK_HZ_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] sig_cnt,
  input  logic [CNT_W-1:0] ref_cnt,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic             busy,
  output logic             div_err,
  output logic             ovf
);

  localparam logic [PROD_W-1:0] REF_K = PROD_W'(REF_CLK_HZ);

  calc_state_e      r_state;
  logic [CNT_W-1:0] r_sig_prev;
  logic [CNT_W-1:0] r_ref_prev;
  logic [CNT_W-1:0] r_sig_op;
  logic [CNT_W-1:0] r_ref_op;
  logic [CNT_W-1:0] r_pend_sig;
  logic [CNT_W-1:0] r_pend_ref;
  logic             r_pend;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_div_err;
  logic             r_ovf;

  logic              w_new;
  logic              w_div_start;
  logic              w_div_done;
  logic [PROD_W-1:0] w_product;
  logic [PROD_W-1:0] w_quotient;

  assign w_new       = (sig_cnt != r_sig_prev) || (ref_cnt != r_ref_prev);
  assign w_product   = {{(PROD_W-CNT_W){1'b0}}, r_sig_op} * REF_K;
  assign w_div_start = (r_state == ST_MUL) && (r_ref_op != '0);

  seq_div_64x32 u_div (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_product),
    .i_divisor  (r_ref_op),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sig_prev <= '0;
      r_ref_prev <= '0;
      r_sig_op   <= '0;
      r_ref_op   <= '0;
      r_pend_sig <= '0;
      r_pend_ref <= '0;
      r_pend     <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_div_err  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_sig_prev <= sig_cnt;
      r_ref_prev <= ref_cnt;
      r_valid    <= 1'b0;

      // Anything arriving while busy parks here; the newest measurement wins.
      if (w_new && (r_state != ST_IDLE)) begin
        r_pend     <= 1'b1;
        r_pend_sig <= sig_cnt;
        r_pend_ref <= ref_cnt;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_new) begin
            r_sig_op <= sig_cnt;
            r_ref_op <= ref_cnt;
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (r_ref_op == '0) begin
            r_freq    <= '0;
            r_ovf     <= 1'b0;
            r_div_err <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_freq    <= sat_to_cnt(w_quotient);
            r_ovf     <= |w_quotient[PROD_W-1:CNT_W];
            r_div_err <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A change seen in this very cycle is newer than the parked one.
          if (w_new) begin
            r_sig_op <= sig_cnt;
            r_ref_op <= ref_cnt;
            r_pend   <= 1'b0;
            r_state  <= ST_MUL;
          end else if (r_pend) begin
            r_sig_op <= r_pend_sig;
            r_ref_op <= r_pend_ref;
            r_pend   <= 1'b0;
            r_state  <= ST_MUL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign freq_hz    = r_freq;
  assign freq_valid = r_valid;
  assign busy       = (r_state != ST_IDLE);
  assign div_err    = r_div_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: expectations queued at stimulus time, popped on freq_valid.
module tb_freq_calc;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] sig_cnt = '0;
  logic [31:0] ref_cnt = '0;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        busy;
  logic        div_err;
  logic        ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [63:0] REF_HZ = 64'd100_000_000;

  typedef struct packed {
    logic [31:0] freq;
    logic        ovf;
    logic        derr;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_freq = '0;

  freq_calc #(.REF_CLK_HZ(100_000_000)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .sig_cnt    (sig_cnt),
    .ref_cnt    (ref_cnt),
    .freq_hz    (freq_hz),
    .freq_valid (freq_valid),
    .busy       (busy),
    .div_err    (div_err),
    .ovf        (ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] s, input logic [31:0] r, input int due);
    exp_t        e;
    logic [63:0] q;
    e.due = due;
    if (r == 0) begin
      e.freq = '0; e.ovf = 1'b0; e.derr = 1'b1;
    end else begin
      q = ({32'd0, s} * REF_HZ) / {32'd0, r};
      e.derr = 1'b0;
      if (q > 64'h0000_0000_FFFF_FFFF) begin
        e.freq = 32'hFFFF_FFFF; e.ovf = 1'b1;
      end else begin
        e.freq = q[31:0]; e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic push_exp(input logic [31:0] f, input logic o, input logic d, input int due);
    exp_t e;
    e.freq = f; e.ovf = o; e.derr = d; e.due = due;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] s, input logic [31:0] r, output int c);
    @(posedge sys_clk); #1;
    sig_cnt = s;
    ref_cnt = r;
    c = cyc;
  endtask

  task automatic wait_sb(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge sys_clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        last_freq = freq_hz;
      end else if (freq_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d freq_hz=%0d required=no pulse", cyc, freq_hz);
        end else begin
          e = sb.pop_front();
          if (freq_hz !== e.freq) begin
            failures++;
            $display("FAIL sb_freq cyc=%0d got=%0d required=%0d", cyc, freq_hz, e.freq);
          end
          checks++;
          if (ovf !== e.ovf) begin
            failures++;
            $display("FAIL sb_ovf cyc=%0d got=%b required=%b", cyc, ovf, e.ovf);
          end
          checks++;
          if (div_err !== e.derr) begin
            failures++;
            $display("FAIL sb_div_err cyc=%0d got=%b required=%b", cyc, div_err, e.derr);
          end
          checks++;
          if (cyc !== e.due) begin
            failures++;
            $display("FAIL sb_latency got_cycle=%0d required_cycle=%0d", cyc, e.due);
          end
        end
        last_freq = freq_hz;
      end else begin
        checks++;
        if (freq_hz !== last_freq) begin
          failures++;
          $display("FAIL hold_freq cyc=%0d got=%0d required=%0d", cyc, freq_hz, last_freq);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (freq_hz !== 32'd0) begin failures++; $display("FAIL rst_freq got=%0d required=0", freq_hz); end
    checks++; if (freq_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", freq_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL rst_div_err got=%b required=0", div_err); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b required=0", ovf); end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_inputs_idle busy=%b required=0", busy); end
  endtask

  task automatic test_basic();
    int c;
    drive(32'd1000, 32'd100_000_000, c);
    push_exp(32'd1000, 1'b0, 1'b0, c + 66);
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_detect_cycle got=%b required=0", busy); end
    @(negedge sys_clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_mul got=%b required=1", busy); end
    wait_sb(100);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_drain pending=%0d required=0", sb.size()); sb.delete(); end
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b required=0", busy); end
  endtask

  task automatic test_ratios();
    int c;
    drive(32'd5, 32'd2, c);
    push_exp(32'd250_000_000, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    drive(32'd7, 32'd3, c);
    push_exp(32'd233_333_333, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    drive(32'd7, 32'd100_000_000, c);
    push_exp(32'd7, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ratios_drain pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_saturation();
    int c;
    drive(32'hFFFF_FFFF, 32'd1, c);
    push_exp(32'hFFFF_FFFF, 1'b1, 1'b0, c + 66);
    wait_sb(100);
    drive(32'hFFFF_FFFF, 32'd100_000_000, c);
    push_exp(32'hFFFF_FFFF, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    drive(32'hFFFF_FFFF, 32'd99_999_999, c);
    sb.push_back(model(32'hFFFF_FFFF, 32'd99_999_999, c + 66));
    wait_sb(100);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sat_drain pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_div_zero();
    int c;
    drive(32'd10, 32'd0, c);
    push_exp(32'd0, 1'b0, 1'b1, c + 2);
    wait_sb(20);
    drive(32'd10, 32'd5, c);
    push_exp(32'd200_000_000, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL divzero_drain pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    int c0;
    int c;
    drive(32'd1000, 32'd1_000_000, c0);
    push_exp(32'd100_000, 1'b0, 1'b0, c0 + 66);
    repeat (9) @(posedge sys_clk);
    drive(32'd2000, 32'd1_000_000, c);
    repeat (9) @(posedge sys_clk);
    drive(32'd3000, 32'd1_000_000, c);
    push_exp(32'd300_000, 1'b0, 1'b0, c0 + 132);
    wait_sb(300);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL pending_latest_drain pending=%0d required=0", sb.size()); sb.delete(); end

    // Change lands exactly in the DONE cycle of the running computation.
    repeat (5) @(posedge sys_clk);
    drive(32'd4000, 32'd1_000_000, c0);
    push_exp(32'd400_000, 1'b0, 1'b0, c0 + 66);
    repeat (65) @(posedge sys_clk);
    drive(32'd5000, 32'd1_000_000, c);
    push_exp(32'd500_000, 1'b0, 1'b0, c0 + 132);
    wait_sb(300);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL done_collision_drain pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_div();
    int c;
    drive(32'd123_456, 32'd1000, c);
    repeat (30) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (freq_hz !== 32'd0) begin failures++; $display("FAIL abort_freq got=%0d required=0", freq_hz); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b required=0", busy); end
    checks++; if (freq_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b required=0", freq_valid); end
    checks++; if ((div_err | ovf) !== 1'b0) begin failures++; $display("FAIL abort_flags got=%b%b required=00", div_err, ovf); end
    sig_cnt = '0;
    ref_cnt = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(posedge sys_clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_no_restart busy=%b required=0", busy); end
    drive(32'd250, 32'd50_000, c);
    push_exp(32'd500_000, 1'b0, 1'b0, c + 66);
    wait_sb(100);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL after_abort_drain pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_random();
    int          c;
    logic [31:0] s;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      s = $urandom;
      case (i % 3)
        0: r = $urandom_range(1, 1000);
        1: r = $urandom_range(1, 1 << 20);
        default: r = $urandom | 32'd1;
      endcase
      if (s == sig_cnt && r == ref_cnt) s = s ^ 32'd1;
      drive(s, r, c);
      sb.push_back(model(s, r, c + 66));
      wait_sb(100);
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL random_drain idx=%0d pending=%0d required=0", i, sb.size()); sb.delete(); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_ratios();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    repeat (5) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
